// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative RV32M divide unit: operation codes,
// controller states and the default datapath width.
package iter_divider_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SPEC = 2'b01,
        CALC = 2'b10,
        FIX  = 2'b11
    } div_state_e;

    // funct3[0] clear selects the two's-complement variants
    function automatic logic op_is_signed(input div_op_e op);
        return !op[0];
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between execute-stage control and the divide unit.
interface iter_divider_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor,
        output busy, done, result
    );
endinterface

// File: rtl/iter_divider_div_step.sv
// One restoring division iteration: shift {rem,quo} left by one, then keep the
// trial subtraction only if it does not borrow.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN:0]   dvsr_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN+1:0] rem_shift;
    logic            no_borrow;

    always_comb begin
        rem_shift = {rem_i, quo_i[XLEN-1]};
        no_borrow = (rem_shift >= {1'b0, dvsr_i});
        if (no_borrow) begin
            rem_o = (XLEN+1)'(rem_shift - {1'b0, dvsr_i});
        end else begin
            rem_o = (XLEN+1)'(rem_shift);
        end
        quo_o = {quo_i[XLEN-2:0], no_borrow};
    end
endmodule

// File: rtl/iter_divider.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: magnitudes are divided one quotient bit
// per clock, then signs are restored; RISC-V special cases bypass the loop.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    iter_divider_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN:0]   dvsr_q, dvsr_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    div_op_e         cur_op;
    logic            cur_signed;
    logic            div_zero;
    logic            overflow;
    logic [XLEN:0]   abs_a;
    logic [XLEN:0]   abs_b;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    // Request decode; magnitudes are XLEN+1 wide so |-2^(XLEN-1)| fits
    always_comb begin
        cur_op     = div_op_e'(bus.op);
        cur_signed = op_is_signed(cur_op);
        div_zero   = (bus.divisor == '0);
        overflow   = cur_signed && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.divisor == '1);
        abs_a = (cur_signed && bus.dividend[XLEN-1])
              ? ((XLEN+1)'(0) - {bus.dividend[XLEN-1], bus.dividend})
              : {1'b0, bus.dividend};
        abs_b = (cur_signed && bus.divisor[XLEN-1])
              ? ((XLEN+1)'(0) - {bus.divisor[XLEN-1], bus.divisor})
              : {1'b0, bus.divisor};
        quo_fix = q_neg_q ? (-quo_q) : quo_q;
        rem_fix = r_neg_q ? (-rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = cur_op;
                    count_d = '0;
                    rem_d   = '0;
                    q_neg_d = cur_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
                    r_neg_d = cur_signed && bus.dividend[XLEN-1];
                    if (div_zero || overflow) begin
                        // Raw operands are parked so SPEC can pick its answer
                        quo_d   = bus.dividend;
                        dvsr_d  = {1'b0, bus.divisor};
                        state_d = SPEC;
                    end else begin
                        quo_d   = XLEN'(abs_a);
                        dvsr_d  = abs_b;
                        state_d = CALC;
                    end
                end
            end
            SPEC: begin
                if (dvsr_q == '0) begin
                    result_d = op_is_rem(op_q) ? quo_q : '1;
                end else begin
                    result_d = op_is_rem(op_q) ? '0 : quo_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 1'b1;
                if (count_d == CW'(XLEN)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= DIV_OP_DIV;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: directed RISC-V cases plus random ops
// checked against an arithmetic reference model, including latency.
module tb_iter_divider;
    import iter_divider_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    exp_t sb[$];

    iter_divider_if #(.XLEN(XLEN)) ifc ();

    iter_divider #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: RISC-V M-extension semantics with plain integer arithmetic
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb_v;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : MIN_INT;
            sa   = longint'($signed(a));
            sb_v = longint'($signed(b));
            return op[1] ? 32'(sa % sb_v) : 32'(sa / sb_v);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && ifc.done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stray_done: done=1 with no request outstanding at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ifc.result !== e.res || cyc != e.done_cyc || ifc.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s: got result=%h cycle=%0d busy=%b, expected result=%h cycle=%0d busy=0",
                             e.name, ifc.result, cyc, ifc.busy, e.res, e.done_cyc);
                end else begin
                    $display("ok   %s: result=%h at cycle %0d", e.name, ifc.result, cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns one time step after the accepting edge
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_it);
        exp_t e;
        ifc.start    = 1'b1;
        ifc.op       = op;
        ifc.dividend = a;
        ifc.divisor  = b;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        if (expect_it) begin
            e.res      = ref_model(op, a, b);
            e.done_cyc = cyc + ref_latency(op, a, b);
            e.name     = name;
            sb.push_back(e);
            check({name, "_busy"}, {31'd0, ifc.busy}, 32'd1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (ifc.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ifc.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=%b, expected 1 within 100 cycles", ifc.done);
        end
    endtask

    initial begin
        logic [31:0] a, b, pool [6];
        logic [1:0]  op;
        cyc          = 0;
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        ifc.start    = 1'b0;
        ifc.op       = 2'b00;
        ifc.dividend = '0;
        ifc.divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, ifc.busy}, 32'd0);
        check("reset_done", {31'd0, ifc.done}, 32'd0);
        check("reset_result", ifc.result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 1); drain();
        issue("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 1); drain();
        issue("div_m7_2",   DIV_OP_DIV, -32'sd7, 32'd2, 1);  drain();
        issue("rem_m7_2",   DIV_OP_REM, -32'sd7, 32'd2, 1);  drain();
        issue("div_7_m2",   DIV_OP_DIV, 32'd7, -32'sd2, 1);  drain();
        issue("rem_7_m2",   DIV_OP_REM, 32'd7, -32'sd2, 1);  drain();
        issue("divu_5_0",   DIV_OP_DIVU, 32'd5, 32'd0, 1);   drain();
        issue("rem_min_0",  DIV_OP_REM, MIN_INT, 32'd0, 1);  drain();
        issue("div_ovf",    DIV_OP_DIV, MIN_INT, 32'hFFFF_FFFF, 1); drain();
        issue("rem_ovf",    DIV_OP_REM, MIN_INT, 32'hFFFF_FFFF, 1); drain();

        // Start during CALC must be ignored; start on the done cycle is taken
        issue("divu_ignore_base", DIV_OP_DIVU, 32'd1000, 32'd9, 1);
        repeat (9) @(negedge clk);
        issue("ignored", DIV_OP_REM, 32'd55, 32'd4, 0);
        @(negedge clk);
        wait_done();
        issue("b2b_div", DIV_OP_DIV, -32'sd100, 32'd7, 1);
        drain();

        // Reset mid-operation aborts without a done
        @(negedge clk);
        issue("aborted", DIV_OP_DIVU, 32'd12345, 32'd3, 0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, ifc.busy}, 32'd0);
        check("abort_done", {31'd0, ifc.done}, 32'd0);
        check("abort_result", ifc.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue("divu_max_1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1); drain();

        // Random ops biased toward boundary operands
        pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF;
        pool[3] = MIN_INT; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'd3;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom >> $urandom_range(0, 31);
            issue($sformatf("rand%0d_op%0d", i, op), op, a, b, 1);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
